// File: rtl/regfile_sb_pkg.sv
// regfile_sb shared constants: default widths, the XZR index
// and the read-port geometry the decode stage sizes its operands from.
package regfile_sb_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int XZR       = 31;
  localparam int RD_PORTS  = 2;
  localparam int RD_ADDR_W = ADDR_W_DEF;
  localparam int RD_DATA_W = DATA_W_DEF;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy scoreboard for outstanding loads: busy vector,
// incrementally maintained busy count and read-hazard stall.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = XZR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sa,
  input  logic [ADDR_W-1:0] sb,
  input  logic              lw,
  input  logic [ADDR_W-1:0] lda,
  input  logic              bset,
  input  logic [ADDR_W-1:0] bda,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_ok;
  logic             bda_after_clr;
  logic             inc, dec;

  always_comb begin
    set_ok = bset &&
      !((ZERO_EN != 0) && (bda == ADDR_W'(ZERO_IDX)));
    // bit state after this edge's clear, seen by the set
    bda_after_clr = busy_q[bda] && !(lw && (lda == bda));
    dec = lw && busy_q[lda];
    inc = set_ok && !bda_after_clr;
    busy_d = busy_q;
    if (lw) busy_d[lda] = 1'b0;
    if (set_ok) busy_d[bda] = 1'b1;
    cnt_d = cnt_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall    = busy_q[sa] | busy_q[sb];
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Two-read / two-write register file with optional XZR,
// same-cycle bypass and a load busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = XZR,
  parameter int BYPASS_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D,
  input  logic              W,
  input  logic [ADDR_W-1:0] LDA,
  input  logic [DATA_W-1:0] LD,
  input  logic              LW,
  input  logic              BSET,
  input  logic [ADDR_W-1:0] BDA,
  output logic              STALL,
  output logic [ADDR_W:0]   BUSY_CNT
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (a == ADDR_W'(ZERO_IDX));
  endfunction

  // load port first so the primary port overrides on conflict
  always_comb begin
    rf_d = rf_q;
    if (LW && !is_zero(LDA)) rf_d[LDA] = LD;
    if (W && !is_zero(DA)) rf_d[DA] = D;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    A = rf_q[SA];
    if ((BYPASS_EN != 0) && reset) begin
      if (W && (DA == SA)) A = D;
      else if (LW && (LDA == SA)) A = LD;
    end
    if (is_zero(SA)) A = '0;
  end

  always_comb begin
    B = rf_q[SB];
    if ((BYPASS_EN != 0) && reset) begin
      if (W && (DA == SB)) B = D;
      else if (LW && (LDA == SB)) B = LD;
    end
    if (is_zero(SB)) B = '0;
  end

  regfile_sb_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_EN (ZERO_EN),
    .ZERO_IDX(ZERO_IDX)
  ) u_sb (
    .clock   (clock),
    .reset   (reset),
    .sa      (SA),
    .sb      (SB),
    .lw      (LW),
    .lda     (LDA),
    .bset    (BSET),
    .bda     (BDA),
    .stall   (STALL),
    .busy_cnt(BUSY_CNT)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb; expectations queued
// by the stimulus and checked by a negedge monitor.
module tb_regfile_sb;
  logic        clock = 0;
  logic        reset = 0;
  logic [4:0]  SA = 0, SB = 0, DA = 0, LDA = 0, BDA = 0;
  logic [63:0] D = 0, LD = 0;
  logic        W = 0, LW = 0, BSET = 0;
  logic [63:0] A, B, A_nb, B_nb;
  logic        STALL, STALL_nb;
  logic [5:0]  BUSY_CNT, CNT_nb;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [63:0] a, b, anb;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;
  exp_t q[$];

  always #5 clock = ~clock;

  regfile_sb dut (
    .clock(clock), .reset(reset), .SA(SA), .SB(SB),
    .A(A), .B(B), .DA(DA), .D(D), .W(W),
    .LDA(LDA), .LD(LD), .LW(LW), .BSET(BSET),
    .BDA(BDA), .STALL(STALL), .BUSY_CNT(BUSY_CNT)
  );

  regfile_sb #(.BYPASS_EN(0)) dut_nb (
    .clock(clock), .reset(reset), .SA(SA), .SB(SB),
    .A(A_nb), .B(B_nb), .DA(DA), .D(D), .W(W),
    .LDA(LDA), .LD(LD), .LW(LW), .BSET(BSET),
    .BDA(BDA), .STALL(STALL_nb), .BUSY_CNT(CNT_nb)
  );

  task automatic chk(input string nm, input string f,
                     input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "A", A, e.a);
      chk(e.nm, "B", B, e.b);
      chk(e.nm, "STALL", {63'd0, STALL}, {63'd0, e.st});
      chk(e.nm, "BUSY_CNT", {58'd0, BUSY_CNT}, {58'd0, e.cnt});
      chk(e.nm, "A_nobyp", A_nb, e.anb);
    end
  end

  task automatic push(input string nm, input logic [63:0] a,
                      input logic [63:0] b, input logic st,
                      input logic [5:0] cnt, input logic [63:0] anb);
    exp_t e;
    e.nm = nm; e.a = a; e.b = b; e.st = st; e.cnt = cnt; e.anb = anb;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm,
                     input logic [4:0] sa, input logic [4:0] sb,
                     input logic w, input logic [4:0] da,
                     input logic [63:0] d,
                     input logic lw, input logic [4:0] lda,
                     input logic [63:0] ld,
                     input logic bs, input logic [4:0] bda,
                     input logic [63:0] ea, input logic [63:0] eb,
                     input logic est, input logic [5:0] ecnt,
                     input logic [63:0] eanb);
    @(posedge clock);
    #1;
    SA = sa; SB = sb; W = w; DA = da; D = d;
    LW = lw; LDA = lda; LD = ld; BSET = bs; BDA = bda;
    push(nm, ea, eb, est, ecnt, eanb);
  endtask

  initial begin
    // name      sa  sb  w da d        lw lda ld      bs bda  A       B    st cnt A_nobyp
    cyc("rst_w",  4,  0, 1, 4, 18,     0, 0, 0,      0, 0,  0,      0,   0, 0, 0);
    @(posedge clock); #1; reset = 1;
    cyc("wr4",    0,  0, 1, 4, 18,     0, 0, 0,      0, 0,  0,      0,   0, 0, 0);
    cyc("wr6",    4,  0, 1, 6, 100,    0, 0, 0,      0, 0,  18,     0,   0, 0, 18);
    cyc("rd46",   4,  6, 0, 0, 0,      0, 0, 0,      0, 0,  18,     100, 0, 0, 18);
    cyc("byp7",   7,  4, 1, 7, 64'h55, 0, 0, 0,      0, 0,  64'h55, 18,  0, 0, 0);
    cyc("rd7",    7,  6, 0, 0, 0,      0, 0, 0,      0, 0,  64'h55, 100, 0, 0, 64'h55);
    cyc("wr_xzr", 31, 31, 1, 31, 64'hFFFF, 0, 0, 0,  0, 0,  0,      0,   0, 0, 0);
    cyc("bs_xzr", 31, 0, 0, 0, 0,      0, 0, 0,      1, 31, 0,      0,   0, 0, 0);
    cyc("bs3",    31, 0, 0, 0, 0,      0, 0, 0,      1, 3,  0,      0,   0, 0, 0);
    cyc("st3",    3,  0, 0, 0, 0,      0, 0, 0,      0, 0,  0,      0,   1, 1, 0);
    cyc("lw3",    3,  0, 0, 0, 0,      1, 3, 64'h1234, 0, 0, 64'h1234, 0, 1, 1, 0);
    cyc("clr3",   3,  0, 0, 0, 0,      0, 0, 0,      0, 0,  64'h1234, 0, 0, 0, 64'h1234);
    cyc("bs5",    0,  0, 0, 0, 0,      0, 0, 0,      1, 5,  0,      0,   0, 0, 0);
    cyc("conf5",  5,  5, 1, 5, 1,      1, 5, 2,      0, 0,  1,      1,   1, 1, 0);
    cyc("rd5",    5,  0, 0, 0, 0,      0, 0, 0,      0, 0,  1,      0,   0, 0, 1);
    cyc("bs9",    0,  0, 0, 0, 0,      0, 0, 0,      1, 9,  0,      0,   0, 0, 0);
    cyc("lwbs9",  9,  0, 0, 0, 0,      1, 9, 64'h99, 1, 9,  64'h99, 0,   1, 1, 0);
    cyc("still9", 9,  0, 0, 0, 0,      0, 0, 0,      0, 0,  64'h99, 0,   1, 1, 64'h99);
    cyc("rebs9",  0,  0, 0, 0, 0,      0, 0, 0,      1, 9,  0,      0,   0, 1, 0);
    cyc("cnt9",   9,  9, 0, 0, 0,      0, 0, 0,      0, 0,  64'h99, 64'h99, 1, 1, 64'h99);
    cyc("lw2nb",  0,  0, 0, 0, 0,      1, 2, 64'h22, 0, 0,  0,      0,   0, 1, 0);
    cyc("rd2",    2,  0, 0, 0, 0,      0, 0, 0,      0, 0,  64'h22, 0,   0, 1, 64'h22);
    cyc("bs1",    2,  0, 0, 0, 0,      0, 0, 0,      1, 1,  64'h22, 0,   0, 1, 64'h22);
    cyc("bs2",    1,  0, 0, 0, 0,      0, 0, 0,      1, 2,  0,      0,   1, 2, 0);
    cyc("bs3b",   1,  2, 0, 0, 0,      0, 0, 0,      1, 3,  0,      64'h22, 1, 3, 0);
    cyc("busy4",  3,  4, 0, 0, 0,      0, 0, 0,      0, 0,  64'h1234, 18, 1, 4, 64'h1234);
    // drop reset between edges: everything must clear at once
    @(posedge clock);
    #3;
    reset = 0;
    push("async_rst", 0, 0, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
